promedio_movil_ctrl: RTL and testbench

Sequencer for the moving-average filter (`filtro_promedio_movil`) in the processing chain. It latches and validates a run configuration (points per cycle, integration frames, sample budget), pulses the filter's reset, and waits for the filter's buffer-clear phase to finish. It then enables the filter for a bounded acquisition and reports completion, FIFO-full termination or errors to the host-side register block.

---
 rtl/pm_ctrl_pkg.sv | 24 ++
 rtl/promedio_movil_ctrl_watchdog.sv | 31 +++
 rtl/promedio_movil_ctrl.sv | 164 ++++++++++++++++
 tb/tb_promedio_movil_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_ctrl_pkg.sv
// Shared types and constants for the moving-average filter sequencer.
// The watchdog sub-block exists only when PM_CTRL_WATCHDOG_EN is defined.
package pm_ctrl_pkg;

    localparam int CNT_W    = 32;
    localparam int PTOS_W   = 16;
    localparam int FRAMES_W = 8;
    localparam int PROD_W   = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_FILT,
        ST_CLEAR,
        ST_RUN,
        ST_FINISH,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CFG  = 2'd1;
    localparam logic [1:0] ERR_CLR  = 2'd2;
    localparam logic [1:0] ERR_WD   = 2'd3;

endpackage

// File: rtl/promedio_movil_ctrl_watchdog.sv
// RUN-phase inactivity watchdog: tracks cycles since the last filter output.
// Instantiated by the sequencer only when PM_CTRL_WATCHDOG_EN is defined.
module pm_ctrl_watchdog
    import pm_ctrl_pkg::*;
#(
    parameter int WD_CYCLES = 65536
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic timeout
);

    logic [CNT_W-1:0] elapsed;

    // elapsed = cycles since the last valid, so the sequencer's registered
    // error lands exactly WD_CYCLES cycles after that valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            elapsed <= CNT_W'(1);
        end else if (!enable || clear) begin
            elapsed <= CNT_W'(1);
        end else begin
            elapsed <= elapsed + CNT_W'(1);
        end
    end

    assign timeout = enable && !clear && (elapsed >= CNT_W'(WD_CYCLES - 1));

endmodule

// File: rtl/promedio_movil_ctrl.sv
// Run sequencer for filtro_promedio_movil: validate config, reset, clear, acquire.
// Optional inactivity watchdog enabled by defining PM_CTRL_WATCHDOG_EN.
module promedio_movil_ctrl
    import pm_ctrl_pkg::*;
#(
    parameter int BUF_TAM     = 4096,
    parameter int RST_CYCLES  = 4,
    parameter int CLR_TIMEOUT = 8192
`ifdef PM_CTRL_WATCHDOG_EN
    ,
    parameter int WD_CYCLES   = 65536
`endif
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [PTOS_W-1:0]   cfg_ptos,
    input  logic [FRAMES_W-1:0] cfg_frames,
    input  logic [CNT_W-1:0]    cfg_muestras,
    output logic                filt_reset_n,
    output logic                filt_enable,
    output logic [15:0]         filt_ptos,
    output logic [15:0]         filt_frames,
    input  logic                filt_ready,
    input  logic                filt_out_valid,
    input  logic                filt_fifo_lleno,
    output logic                busy,
    output logic                done,
    output logic                lleno,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [CNT_W-1:0]    muestras_cnt
);

    state_t             state;
    logic [7:0]         rst_cnt;
    logic [31:0]        clr_cnt;
    logic [CNT_W-1:0]   target;
    logic               cfg_bad_q;
    logic [PROD_W-1:0]  prod;
    logic               cfg_bad;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit_target;
    logic               wd_en;
    logic               wd_timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign prod       = PROD_W'(cfg_ptos) * PROD_W'(cfg_frames);
    assign cfg_bad    = (cfg_ptos == '0) || (cfg_frames == '0) || (prod > PROD_W'(BUF_TAM));
    assign cnt_inc    = filt_out_valid ? sat_inc(muestras_cnt) : muestras_cnt;
    assign hit_target = (target != '0) && (cnt_inc >= target);
    assign wd_en      = (state == ST_RUN);

`ifdef PM_CTRL_WATCHDOG_EN
    pm_ctrl_watchdog #(
        .WD_CYCLES (WD_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (wd_en),
        .clear   (filt_out_valid),
        .timeout (wd_timeout)
    );
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            filt_reset_n <= 1'b0;
            filt_enable  <= 1'b0;
            filt_ptos    <= '0;
            filt_frames  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            lleno        <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            muestras_cnt <= '0;
            target       <= '0;
            rst_cnt      <= '0;
            clr_cnt      <= '0;
            cfg_bad_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state        <= ST_IDLE;
                filt_enable  <= 1'b0;
                filt_reset_n <= 1'b1;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        filt_reset_n <= 1'b1;
                        if (start) begin
                            filt_ptos    <= cfg_ptos;
                            filt_frames  <= 16'(cfg_frames);
                            target       <= cfg_muestras;
                            error        <= 1'b0;
                            err_code     <= ERR_NONE;
                            lleno        <= 1'b0;
                            muestras_cnt <= '0;
                            // a rejected config never pulses the filter reset
                            cfg_bad_q    <= cfg_bad;
                            filt_reset_n <= cfg_bad;
                            rst_cnt      <= 8'd1;
                            busy         <= 1'b1;
                            state        <= ST_RST_FILT;
                        end
                    end
                    ST_RST_FILT: begin
                        if (cfg_bad_q) begin
                            error    <= 1'b1;
                            err_code <= ERR_CFG;
                            state    <= ST_ERROR;
                        end else if (rst_cnt == 8'(RST_CYCLES)) begin
                            filt_reset_n <= 1'b1;
                            clr_cnt      <= '0;
                            state        <= ST_CLEAR;
                        end else begin
                            rst_cnt <= rst_cnt + 8'd1;
                        end
                    end
                    ST_CLEAR: begin
                        if (filt_ready) begin
                            filt_enable <= 1'b1;
                            state       <= ST_RUN;
                        end else if (clr_cnt == 32'(CLR_TIMEOUT - 1)) begin
                            error    <= 1'b1;
                            err_code <= ERR_CLR;
                            state    <= ST_ERROR;
                        end else begin
                            clr_cnt <= clr_cnt + 32'd1;
                        end
                    end
                    ST_RUN: begin
                        muestras_cnt <= cnt_inc;
                        if (filt_fifo_lleno || hit_target) begin
                            if (filt_fifo_lleno) lleno <= 1'b1;
                            filt_enable <= 1'b0;
                            done        <= 1'b1;
                            state       <= ST_FINISH;
                        end else if (wd_timeout) begin
                            filt_enable <= 1'b0;
                            error       <= 1'b1;
                            err_code    <= ERR_WD;
                            state       <= ST_ERROR;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_promedio_movil_ctrl.sv
// Scenario bench for promedio_movil_ctrl; end-of-run results checked via a queue.
// Watchdog scenario follows PM_CTRL_WATCHDOG_EN when the RTL is built with it.
`timescale 1ns/1ps
module tb_promedio_movil_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_ptos = '0;
    logic [7:0]  cfg_frames = '0;
    logic [31:0] cfg_muestras = '0;
    logic        filt_reset_n;
    logic        filt_enable;
    logic [15:0] filt_ptos;
    logic [15:0] filt_frames;
    logic        filt_ready = 1'b0;
    logic        filt_out_valid = 1'b0;
    logic        filt_fifo_lleno = 1'b0;
    logic        busy;
    logic        done;
    logic        lleno;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] muestras_cnt;

    typedef struct {
        logic [31:0] cnt;
        logic        lleno;
        logic        error;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    promedio_movil_ctrl #(
        .BUF_TAM     (4096),
        .RST_CYCLES  (4),
        .CLR_TIMEOUT (8192)
`ifdef PM_CTRL_WATCHDOG_EN
        ,
        .WD_CYCLES   (100)
`endif
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .cfg_ptos        (cfg_ptos),
        .cfg_frames      (cfg_frames),
        .cfg_muestras    (cfg_muestras),
        .filt_reset_n    (filt_reset_n),
        .filt_enable     (filt_enable),
        .filt_ptos       (filt_ptos),
        .filt_frames     (filt_frames),
        .filt_ready      (filt_ready),
        .filt_out_valid  (filt_out_valid),
        .filt_fifo_lleno (filt_fifo_lleno),
        .busy            (busy),
        .done            (done),
        .lleno           (lleno),
        .error           (error),
        .err_code        (err_code),
        .muestras_cnt    (muestras_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL tb_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_and_check(input string name);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb: got empty queue want one entry", name);
        end else begin
            e = sb.pop_front();
            if ({muestras_cnt, lleno, error, err_code} !== {e.cnt, e.lleno, e.error, e.code}) begin
                n_err++;
                $display("FAIL %s_result: got cnt=%0d lleno=%b error=%b code=%0d want cnt=%0d lleno=%b error=%b code=%0d",
                         name, muestras_cnt, lleno, error, err_code, e.cnt, e.lleno, e.error, e.code);
            end
        end
    endtask

    // Start a run and bring it into RUN with filt_ready after ready_delay CLEAR cycles.
    task automatic enter_run(input logic [15:0] m, input logic [7:0] n, input logic [31:0] ms,
                             input int ready_delay);
        int k;
        cfg_ptos = m; cfg_frames = n; cfg_muestras = ms;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (filt_reset_n == 1'b0 && k < 300) begin
            k++;
            tick();
        end
        repeat (ready_delay) tick();
        filt_ready = 1'b1;
        tick();
        filt_ready = 1'b0;
        n_cmp++;
        if (filt_enable !== 1'b1) begin
            n_err++;
            $display("FAIL enter_run_enable: got %b want 1", filt_enable);
        end
    endtask

    // Drive n valids (random gaps when gaps=1); counts done pulses seen before the last one.
    task automatic send_valids(input int n, input bit gaps, output int early_done);
        int sent;
        logic v;
        sent = 0;
        early_done = 0;
        while (sent < n) begin
            if (done) early_done++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            filt_out_valid = v;
            tick();
            if (v) sent++;
        end
        filt_out_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({filt_reset_n, filt_enable, busy, done, lleno, error, err_code} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {filt_reset_n, filt_enable, busy, done, lleno, error, err_code});
        end
        n_cmp++;
        if ({muestras_cnt, filt_ptos, filt_frames} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {muestras_cnt, filt_ptos, filt_frames});
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (filt_reset_n !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got filt_reset_n=%b busy=%b want 1 0", filt_reset_n, busy);
        end
    endtask

    task automatic test_normal_run();
        int low, en_bad, early;
        cfg_ptos = 16'd64; cfg_frames = 8'd4; cfg_muestras = 32'd1000;
        sb.push_back('{cnt: 32'd1000, lleno: 1'b0, error: 1'b0, code: 2'd0});
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL normal_busy: got %b want 1", busy);
        end
        low = 0;
        while (filt_reset_n == 1'b0 && low < 300) begin
            low++;
            tick();
        end
        n_cmp++;
        if (low != 4) begin
            n_err++;
            $display("FAIL normal_rst_len: got %0d want 4", low);
        end
        n_cmp++;
        if (filt_ptos !== 16'd64 || filt_frames !== 16'd4) begin
            n_err++;
            $display("FAIL normal_latch: got %0d/%0d want 64/4", filt_ptos, filt_frames);
        end
        en_bad = 0;
        repeat (4096) begin
            if (filt_enable) en_bad++;
            tick();
        end
        n_cmp++;
        if (en_bad != 0) begin
            n_err++;
            $display("FAIL normal_clear_enable: got %0d cycles enabled want 0", en_bad);
        end
        filt_ready = 1'b1;
        tick();
        filt_ready = 1'b0;
        n_cmp++;
        if (filt_enable !== 1'b1) begin
            n_err++;
            $display("FAIL normal_enable: got %b want 1", filt_enable);
        end
        send_valids(1000, 1'b1, early);
        filt_out_valid = 1'b1;
        n_cmp++;
        if (early != 0 || done !== 1'b1 || filt_enable !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL normal_done: got early=%0d done=%b en=%b busy=%b want 0 1 0 1",
                     early, done, filt_enable, busy);
        end
        tick();
        filt_out_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL normal_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        pop_and_check("normal");
    endtask

    task automatic test_bad_cfg(input logic [15:0] m, input logic [7:0] n, input string name);
        int pulses;
        cfg_ptos = m; cfg_frames = n; cfg_muestras = 32'd10;
        sb.push_back('{cnt: 32'd0, lleno: 1'b0, error: 1'b1, code: 2'd1});
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = filt_reset_n ? 0 : 1;
        n_cmp++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            n_err++;
            $display("FAIL %s_t1: got busy=%b error=%b want 1 0", name, busy, error);
        end
        tick();
        if (!filt_reset_n) pulses++;
        n_cmp++;
        if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_t2: got error=%b code=%0d busy=%b want 1 1 1", name, error, err_code, busy);
        end
        tick();
        if (!filt_reset_n || done) pulses++;
        n_cmp++;
        if (busy !== 1'b0 || pulses != 0) begin
            n_err++;
            $display("FAIL %s_t3: got busy=%b rst/done pulses=%0d want 0 0", name, busy, pulses);
        end
        pop_and_check(name);
    endtask

    task automatic test_boundary_cfg();
        cfg_ptos = 16'd1024; cfg_frames = 8'd4; cfg_muestras = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (filt_reset_n !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_accept: got filt_reset_n=%b error=%b want 0 0", filt_reset_n, error);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || filt_reset_n !== 1'b1 || error !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_abort: got busy=%b filt_reset_n=%b error=%b want 0 1 0",
                     busy, filt_reset_n, error);
        end
    endtask

    task automatic test_clear_timeout();
        int k, en_seen;
        cfg_ptos = 16'd64; cfg_frames = 8'd4; cfg_muestras = 32'd100;
        sb.push_back('{cnt: 32'd0, lleno: 1'b0, error: 1'b1, code: 2'd2});
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        en_seen = 0;
        while (!error && k < 9000) begin
            if (filt_enable) en_seen++;
            tick();
            k++;
        end
        n_cmp++;
        if (k != 8197 || en_seen != 0) begin
            n_err++;
            $display("FAIL clr_timeout: got error at t+%0d enable cycles=%0d want t+8197 0", k, en_seen);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL clr_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        pop_and_check("clr");
    endtask

    task automatic test_fifo_lleno();
        int early;
        sb.push_back('{cnt: 32'd500, lleno: 1'b1, error: 1'b0, code: 2'd0});
        enter_run(16'd100, 8'd8, 32'd0, 7);
        send_valids(500, 1'b1, early);
        filt_fifo_lleno = 1'b1;
        tick();
        filt_fifo_lleno = 1'b0;
        n_cmp++;
        if (early != 0 || done !== 1'b1 || lleno !== 1'b1 || filt_enable !== 1'b0) begin
            n_err++;
            $display("FAIL lleno_done: got early=%0d done=%b lleno=%b en=%b want 0 1 1 0",
                     early, done, lleno, filt_enable);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL lleno_idle: got busy=%b want 0", busy);
        end
        pop_and_check("lleno");
    endtask

    task automatic test_abort_and_restart();
        int early;
        enter_run(16'd32, 8'd2, 32'd0, 3);
        send_valids(10, 1'b0, early);
        abort = 1'b1;
        start = 1'b1;
        cfg_ptos = 16'd77;
        tick();
        abort = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || filt_enable !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%b en=%b done=%b error=%b want 0 0 0 0",
                     busy, filt_enable, done, error);
        end
        n_cmp++;
        if (muestras_cnt !== 32'd10 || filt_ptos !== 16'd32) begin
            n_err++;
            $display("FAIL abort_frozen: got cnt=%0d ptos=%0d want 10 32", muestras_cnt, filt_ptos);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_start_ignored: got busy=%b want 0", busy);
        end
        sb.push_back('{cnt: 32'd5, lleno: 1'b0, error: 1'b0, code: 2'd0});
        enter_run(16'd16, 8'd8, 32'd5, 0);
        send_valids(5, 1'b0, early);
        n_cmp++;
        if (early != 0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_done: got early=%0d done=%b want 0 1", early, done);
        end
        tick();
        pop_and_check("restart");
    endtask

    task automatic test_watchdog();
        int early;
`ifdef PM_CTRL_WATCHDOG_EN
        int k;
        sb.push_back('{cnt: 32'd20, lleno: 1'b0, error: 1'b1, code: 2'd3});
        enter_run(16'd64, 8'd4, 32'd0, 2);
        send_valids(20, 1'b0, early);
        k = 1;
        while (!error && k < 400) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k != 100 || err_code !== 2'd3 || filt_enable !== 1'b0) begin
            n_err++;
            $display("FAIL wd_timeout: got error at v+%0d code=%0d en=%b want v+100 3 0",
                     k, err_code, filt_enable);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL wd_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        pop_and_check("wd");
`else
        enter_run(16'd64, 8'd4, 32'd0, 2);
        send_valids(20, 1'b0, early);
        repeat (300) tick();
        n_cmp++;
        if (busy !== 1'b1 || filt_enable !== 1'b1 || error !== 1'b0 || early != 0) begin
            n_err++;
            $display("FAIL no_wd_run: got busy=%b en=%b error=%b early=%0d want 1 1 0 0",
                     busy, filt_enable, error, early);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || muestras_cnt !== 32'd20) begin
            n_err++;
            $display("FAIL no_wd_abort: got busy=%b cnt=%0d want 0 20", busy, muestras_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_bad_cfg(16'd2048, 8'd4, "bad_prod");
        test_bad_cfg(16'd0, 8'd4, "bad_m0");
        test_bad_cfg(16'd8, 8'd0, "bad_n0");
        test_boundary_cfg();
        test_clear_timeout();
        test_fifo_lleno();
        test_abort_and_restart();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
